// File: rtl/reg_wb_queue_if.sv
// Handshake and result bus between the producers/decode and the write-back queue.
// master: ALU/load producers, decode lookup and register file side.
// slave:  the queue itself.
interface reg_wb_if #(
  parameter int n = 5,
  parameter int m = 32
);
  logic         alu_valid;
  logic         alu_ready;
  logic [n-1:0] alu_addr;
  logic [m-1:0] alu_data;
  logic         mem_valid;
  logic         mem_ready;
  logic [n-1:0] mem_addr;
  logic [m-1:0] mem_data;
  logic [n-1:0] wb_addr;
  logic [m-1:0] wb_data;
  logic         wb_we;
  logic [n-1:0] byp_addr;
  logic         byp_hit;
  logic [m-1:0] byp_data;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, byp_addr,
    input  alu_ready, mem_ready, wb_addr, wb_data, wb_we, byp_hit, byp_data
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, byp_addr,
    output alu_ready, mem_ready, wb_addr, wb_data, wb_we, byp_hit, byp_data
  );
endinterface

// File: rtl/reg_wb_queue.sv
// Write-back queue in front of the register file write port.
// Two producers (load path, ALU) push into an in-order FIFO; one entry drains
// per cycle into registered wb_addr/wb_data/wb_we.
// Define WB_BYPASS_EN to build the decode-stage bypass lookup; without it
// byp_hit/byp_data are tied to zero.
module reg_wb_queue #(
  parameter int n     = 5,
  parameter int m     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  reg_wb_if.slave                  bus,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [n-1:0] addr;
    logic [m-1:0] data;
  } entry_t;

  entry_t        fifo [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW-1:0] alu_slot;
  logic          mem_push, alu_push, pop;

  // Ready looks only at the registered count; a same-cycle pop is not credited,
  // so a push can never collide with a full queue.
  assign bus.mem_ready = (count < FULL);
  assign bus.alu_ready = bus.mem_valid ? (count < FULL - CW'(1)) : (count < FULL);

  // Register 0 writes complete the handshake but are dropped.
  assign mem_push = bus.mem_valid & bus.mem_ready & (bus.mem_addr != '0);
  assign alu_push = bus.alu_valid & bus.alu_ready & (bus.alu_addr != '0);
  assign pop      = (count != '0);
  // The load entry is older, so the ALU entry lands behind it.
  assign alu_slot = tail + AW'(mem_push);

  // FIFO storage; validity is tracked by head/count, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (mem_push) fifo[tail]     <= '{addr: bus.mem_addr, data: bus.mem_data};
    if (alu_push) fifo[alu_slot] <= '{addr: bus.alu_addr, data: bus.alu_data};
  end

  // Pointers, occupancy and the registered write-back stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      bus.wb_we   <= 1'b0;
      bus.wb_addr <= '0;
      bus.wb_data <= '0;
    end else begin
      tail  <= tail + AW'(mem_push) + AW'(alu_push);
      count <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
      bus.wb_we <= pop;
      if (pop) begin
        head        <= head + AW'(1);
        bus.wb_addr <= fifo[head].addr;
        bus.wb_data <= fifo[head].data;
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Bypass search: wb stage is the oldest candidate, then FIFO oldest to
  // youngest, so the last match (youngest) overrides earlier ones.
  always_comb begin
    bus.byp_hit  = 1'b0;
    bus.byp_data = '0;
    if (bus.byp_addr != '0) begin
      if (bus.wb_we && (bus.wb_addr == bus.byp_addr)) begin
        bus.byp_hit  = 1'b1;
        bus.byp_data = bus.wb_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < count) && (fifo[head + AW'(i)].addr == bus.byp_addr)) begin
          bus.byp_hit  = 1'b1;
          bus.byp_data = fifo[head + AW'(i)].data;
        end
      end
    end
  end
`else
  logic unused_byp;
  assign unused_byp   = ^bus.byp_addr;
  assign bus.byp_hit  = 1'b0;
  assign bus.byp_data = '0;
`endif
endmodule

// File: tb/tb_reg_wb_queue.sv
// Scoreboard bench for reg_wb_queue: accepted entries are queued as expected
// register file writes; a monitor pops and compares on every wb_we pulse.
module tb_reg_wb_queue;
  localparam int N = 5;
  localparam int M = 32;
  localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0] a;
    logic [M-1:0] d;
  } wb_t;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [$clog2(DEPTH):0]  count;
  int                      total = 0;
  int                      bad = 0;
  int                      mcnt = 0;
  wb_t                     sb[$];

  reg_wb_if #(.n(N), .m(M)) bus ();

  reg_wb_queue #(.n(N), .m(M), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus: apply inputs, check ready/count against the model
  // at negedge, record accepted entries, advance past the next posedge.
  task automatic step(input logic mv, input logic [N-1:0] ma, input logic [M-1:0] md,
                      input logic av, input logic [N-1:0] aa, input logic [M-1:0] ad);
    logic mr, ar;
    int   pushes;
    wb_t  e;
    bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    @(negedge clk);
    mr = (mcnt < DEPTH);
    ar = mv ? (mcnt <= DEPTH - 2) : (mcnt < DEPTH);
    chk("count", count, mcnt);
    chk("mem_ready", bus.mem_ready, mr);
    chk("alu_ready", bus.alu_ready, ar);
    pushes = 0;
    if (mv && mr && ma != 0) begin e = {ma, md}; sb.push_back(e); pushes++; end
    if (av && ar && aa != 0) begin e = {aa, ad}; sb.push_back(e); pushes++; end
    @(posedge clk);
    mcnt = mcnt + pushes - ((mcnt > 0) ? 1 : 0);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Monitor: every register file write must match the oldest expected entry.
  always @(negedge clk) begin
    wb_t e;
    if (rst_n && bus.wb_we) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL wb_unexpected: got r%0d=%0h want no write", bus.wb_addr, bus.wb_data);
      end else begin
        e = sb.pop_front();
        chk("wb_addr", bus.wb_addr, e.a);
        chk("wb_data", bus.wb_data, e.d);
      end
    end
  end

  initial begin
    bus.mem_valid = 0; bus.mem_addr = '0; bus.mem_data = '0;
    bus.alu_valid = 0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.byp_addr = '0;

    // reset values
    #2;
    chk("rst_wb_we", bus.wb_we, 0);
    chk("rst_wb_addr", bus.wb_addr, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_count", count, 0);
    chk("rst_byp_hit", bus.byp_hit, 0);
    chk("rst_byp_data", bus.byp_data, 0);
    chk("rst_mem_ready", bus.mem_ready, 1);
    chk("rst_alu_ready", bus.alu_ready, 1);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // single ALU write: accept edge k, wb_* after k+1, gone after k+2
    step(1'b0, '0, '0, 1'b1, 5'd3, 32'hDEADBEEF);
    chk("single_we_early", bus.wb_we, 0);
    idle();
    chk("single_we", bus.wb_we, 1);
    chk("single_addr", bus.wb_addr, 3);
    chk("single_data", bus.wb_data, 32'hDEADBEEF);
    idle();
    chk("single_we_off", bus.wb_we, 0);

    // bypass through FIFO and wb stage
    bus.byp_addr = 5'd9;
    step(1'b0, '0, '0, 1'b1, 5'd9, 32'h99);
    chk("byp9_fifo_hit", bus.byp_hit, BYP);
    chk("byp9_fifo_data", bus.byp_data, BYP ? 32'h99 : 32'h0);
    idle();
    chk("byp9_wb_hit", bus.byp_hit, BYP);
    chk("byp9_wb_data", bus.byp_data, BYP ? 32'h99 : 32'h0);
    idle();
    chk("byp9_done_hit", bus.byp_hit, 0);
    chk("byp9_done_data", bus.byp_data, 0);

    // simultaneous push to the same destination: mem first, ALU wins
    bus.byp_addr = 5'd7;
    step(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
    chk("same_byp_q", bus.byp_data, BYP ? 32'hB : 32'h0);
    idle();
    chk("same_wb_first", bus.wb_data, 32'hA);
    chk("same_byp_1", bus.byp_data, BYP ? 32'hB : 32'h0);
    idle();
    chk("same_wb_second", bus.wb_data, 32'hB);
    chk("same_byp_2", bus.byp_data, BYP ? 32'hB : 32'h0);
    idle();
    chk("same_byp_done", bus.byp_hit, 0);

    // register 0: handshake completes, nothing enqueued
    bus.byp_addr = 5'd0;
    step(1'b0, '0, '0, 1'b1, 5'd0, 32'h55);
    chk("r0_count", count, 0);
    chk("r0_byp_hit", bus.byp_hit, 0);
    idle();
    chk("r0_no_we", bus.wb_we, 0);

    // backpressure: dual issue every cycle, then ALU-only at high occupancy
    for (int i = 0; i < 6; i++)
      step(1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b1, 5'(i + 10), 32'h200 + 32'(i));
    step(1'b0, '0, '0, 1'b1, 5'd20, 32'h300);
    for (int i = 0; i < 5; i++) idle();

    // random traffic
    for (int i = 0; i < 50; i++)
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    for (int i = 0; i < 8; i++) idle();
    chk("random_drained", sb.size(), 0);

    // reset mid-traffic
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    step(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4);
    chk("pre_rst_count", count, 3);
    #1;
    rst_n = 1'b0;
    sb.delete();
    mcnt = 0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_we", bus.wb_we, 0);
    bus.mem_valid = 0; bus.alu_valid = 0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b0, '0, '0, 1'b1, 5'd5, 32'h11);
    chk("post_rst_we_early", bus.wb_we, 0);
    idle();
    chk("post_rst_we", bus.wb_we, 1);
    chk("post_rst_addr", bus.wb_addr, 5);
    chk("post_rst_data", bus.wb_data, 32'h11);
    for (int i = 0; i < 3; i++) idle();
    chk("final_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
